// File: rtl/ofm_writeback_if.sv
// Tile handshake and OFM write port of the output-feature-map writeback block.
// The slave modport is the writeback block; master is the tile producer and OFM memory side.
interface ofm_writeback_if #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 15
);
    logic                               acc_valid;
    logic                               acc_ready;
    logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0] acc_data;
    logic                               ofm_we;
    logic [ADDR_WIDTH-1:0]              ofm_addr;
    logic [DATA_WIDTH-1:0]              ofm_wdata;

    modport master (
        output acc_valid,
        output acc_data,
        input  acc_ready,
        input  ofm_we,
        input  ofm_addr,
        input  ofm_wdata
    );

    modport slave (
        input  acc_valid,
        input  acc_data,
        output acc_ready,
        output ofm_we,
        output ofm_addr,
        output ofm_wdata
    );
endinterface

// File: rtl/ofm_writeback.sv
// Drains accumulator tiles into the OFM memory: ReLU, rounding right-shift and saturation
// per element, one write per cycle, tiles ordered segment, then row, then filter.
module ofm_writeback #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned ACC_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned NUM_FILTERS   = 16,
    parameter int unsigned OUT_H         = 32,
    parameter int unsigned OUT_W         = 32,
    parameter int unsigned ADDR_WIDTH    = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_i,
    input  logic           relu_en_i,
    input  logic [4:0]     shift_i,
    output logic           busy_o,
    output logic           done_o,
    ofm_writeback_if.slave wb
);
    localparam int unsigned Segs = OUT_W / SYSTOLIC_SIZE;
    localparam int unsigned KW   = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int unsigned FW   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
    localparam int unsigned RW   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int unsigned SW   = (Segs > 1) ? $clog2(Segs) : 1;
    localparam int unsigned ExtW = ACC_WIDTH + 1;

    localparam logic signed [ExtW-1:0] SatMax = ExtW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ExtW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {StIdle, StWaitTile, StDrain, StFinish} state_e;

    state_e                             state_q;
    logic                               relu_q;
    logic [4:0]                         shift_q;
    logic [FW-1:0]                      f_q;
    logic [RW-1:0]                      r_q;
    logic [SW-1:0]                      s_q;
    logic [KW-1:0]                      k_q;
    logic [SYSTOLIC_SIZE*ACC_WIDTH-1:0] tile_q;
    logic                               acc_ready_q;
    logic                               we_q;
    logic [ADDR_WIDTH-1:0]              addr_q;
    logic [DATA_WIDTH-1:0]              wdata_q;
    logic                               busy_q;
    logic                               done_q;

    logic [KW-1:0]          k_next;
    logic [ACC_WIDTH-1:0]   conv_in;
    logic signed [ExtW-1:0] ext;
    logic signed [ExtW-1:0] rnd;
    logic signed [ExtW-1:0] shifted;
    logic [DATA_WIDTH-1:0]  conv_out;
    logic [ADDR_WIDTH-1:0]  base_addr;
    logic                   last_elem;
    logic                   last_seg;
    logic                   last_row;
    logic                   last_filt;

    // Element 0 is converted straight off the bus at the handshake so the first write
    // lands in the next cycle; later elements come from the latched tile, one ahead of k.
    always_comb begin
        k_next  = k_q + KW'(1);
        conv_in = (state_q == StWaitTile) ? wb.acc_data[ACC_WIDTH-1:0]
                                          : tile_q[int'(k_next)*ACC_WIDTH +: ACC_WIDTH];
        ext = $signed({conv_in[ACC_WIDTH-1], conv_in});
        if (relu_q && ext[ExtW-1]) begin
            ext = '0;
        end
        rnd     = '0;
        shifted = ext;
        if (shift_q != 5'd0) begin
            rnd     = ExtW'(1) << (shift_q - 5'd1);
            shifted = (ext + rnd) >>> shift_q;
        end
        if (shifted > SatMax) begin
            conv_out = SatMax[DATA_WIDTH-1:0];
        end else if (shifted < SatMin) begin
            conv_out = SatMin[DATA_WIDTH-1:0];
        end else begin
            conv_out = shifted[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        base_addr = ADDR_WIDTH'((32'(f_q) * OUT_H + 32'(r_q)) * OUT_W
                                + 32'(s_q) * SYSTOLIC_SIZE);
        last_elem = (k_q == KW'(SYSTOLIC_SIZE - 1));
        last_seg  = (s_q == SW'(Segs - 1));
        last_row  = (r_q == RW'(OUT_H - 1));
        last_filt = (f_q == FW'(NUM_FILTERS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            relu_q      <= 1'b0;
            shift_q     <= '0;
            f_q         <= '0;
            r_q         <= '0;
            s_q         <= '0;
            k_q         <= '0;
            tile_q      <= '0;
            acc_ready_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q     <= StWaitTile;
                        relu_q      <= relu_en_i;
                        shift_q     <= shift_i;
                        f_q         <= '0;
                        r_q         <= '0;
                        s_q         <= '0;
                        acc_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                StWaitTile: begin
                    if (wb.acc_valid) begin
                        state_q     <= StDrain;
                        tile_q      <= wb.acc_data;
                        acc_ready_q <= 1'b0;
                        k_q         <= '0;
                        we_q        <= 1'b1;
                        addr_q      <= base_addr;
                        wdata_q     <= conv_out;
                    end
                end
                StDrain: begin
                    if (last_elem) begin
                        if (last_seg && last_row && last_filt) begin
                            state_q <= StFinish;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= StWaitTile;
                            acc_ready_q <= 1'b1;
                        end
                        if (last_seg) begin
                            s_q <= '0;
                            if (last_row) begin
                                r_q <= '0;
                                f_q <= last_filt ? '0 : f_q + FW'(1);
                            end else begin
                                r_q <= r_q + RW'(1);
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end else begin
                        k_q     <= k_next;
                        we_q    <= 1'b1;
                        addr_q  <= addr_q + ADDR_WIDTH'(1);
                        wdata_q <= conv_out;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign wb.acc_ready = acc_ready_q;
    assign wb.ofm_we    = we_q;
    assign wb.ofm_addr  = addr_q;
    assign wb.ofm_wdata = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Self-checking bench for ofm_writeback: conversion table, directed corner cases,
// randomized tiles against a linear-address arithmetic model, and one full layer.
module tb_ofm_writeback;
    localparam int S      = 16;
    localparam int AW     = 32;
    localparam int DW     = 8;
    localparam int NF     = 16;
    localparam int OH     = 32;
    localparam int OW     = 32;
    localparam int ADW    = 15;
    localparam int NTILES = NF * OH * (OW / S);

    typedef struct packed {
        logic             relu;
        logic [4:0]       shift;
        logic [0:3][31:0] acc;
        logic [0:3][31:0] exp;
    } vec_t;

    typedef struct packed {
        logic [ADW-1:0] addr;
        logic [DW-1:0]  data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       relu_en;
    logic [4:0] shift;
    logic       busy;
    logic       done;

    int n_vec     = 0;
    int n_err     = 0;
    int done_cnt  = 0;
    int write_cnt = 0;
    int tile_idx  = 0;
    bit cur_relu;
    int cur_shift;

    wr_t              exp_q[$];
    vec_t             tbl[7];
    logic [S*AW-1:0]  tdata;
    logic [S*DW-1:0]  texp;

    ofm_writeback_if #(
        .SYSTOLIC_SIZE(S),
        .ACC_WIDTH    (AW),
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (ADW)
    ) wb ();

    ofm_writeback #(
        .SYSTOLIC_SIZE(S),
        .ACC_WIDTH    (AW),
        .DATA_WIDTH   (DW),
        .NUM_FILTERS  (NF),
        .OUT_H        (OH),
        .OUT_W        (OW),
        .ADDR_WIDTH   (ADW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .relu_en_i(relu_en),
        .shift_i  (shift),
        .busy_o   (busy),
        .done_o   (done),
        .wb       (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference conversion in plain integer arithmetic (>>> on longint is a floor divide).
    function automatic longint model(input longint acc, input bit relu, input int sh);
        longint v = acc;
        if (relu && v < 0) v = 0;
        if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
        if (v > (2 ** (DW - 1)) - 1) v = (2 ** (DW - 1)) - 1;
        if (v < -(2 ** (DW - 1))) v = -(2 ** (DW - 1));
        return v;
    endfunction

    // Every write is popped against the expected stream (address = tile*S + k).
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            check("busy_low_with_done", longint'(busy), 0);
        end
        if (wb.ofm_we === 1'b1) begin
            wr_t e;
            write_cnt++;
            check("write_expected", longint'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ofm_addr", longint'(wb.ofm_addr), longint'(e.addr));
                check("ofm_wdata", longint'($signed(wb.ofm_wdata)), longint'($signed(e.data)));
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_acc_ready", longint'(wb.acc_ready), 0);
        check("rst_ofm_we", longint'(wb.ofm_we), 0);
        check("rst_ofm_addr", longint'(wb.ofm_addr), 0);
        check("rst_ofm_wdata", longint'(wb.ofm_wdata), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        start        = 1'b0;
        wb.acc_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic start_layer(input bit r, input logic [4:0] sh);
        relu_en   = r;
        shift     = sh;
        start     = 1'b1;
        cur_relu  = r;
        cur_shift = int'(sh);
        tile_idx  = 0;
        @(negedge clk);
        start   = 1'b0;
        relu_en = ~r;
        shift   = ~sh;
        check("busy_after_start", longint'(busy), 1);
        check("ready_after_start", longint'(wb.acc_ready), 1);
    endtask

    task automatic send_tile(input logic [S*AW-1:0] data, input logic [S*DW-1:0] expd);
        int w = 0;
        while (wb.acc_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_within_bound", longint'(wb.acc_ready === 1'b1), 1);
        if (wb.acc_ready !== 1'b1) return;
        wb.acc_data  = data;
        wb.acc_valid = 1'b1;
        for (int k = 0; k < S; k++) begin
            exp_q.push_back('{addr: ADW'(tile_idx * S + k), data: expd[k*DW +: DW]});
        end
        tile_idx++;
        @(negedge clk);
        wb.acc_valid = 1'b0;
        check("first_write_next_cycle", longint'(wb.ofm_we), 1);
        check("ready_low_in_drain", longint'(wb.acc_ready), 0);
    endtask

    task automatic drain_wait();
        int w = 0;
        while (exp_q.size() != 0 && w < 4 * S) begin
            @(negedge clk);
            w++;
        end
        check("queue_drained", longint'(exp_q.size()), 0);
    endtask

    task automatic build_ramp();
        for (int k = 0; k < S; k++) begin
            tdata[k*AW +: AW] = AW'(k - 8);
            texp[k*DW +: DW]  = DW'(k - 8);
        end
    endtask

    task automatic build_random();
        int span = (cur_shift < 22) ? (1 << (cur_shift + 8)) : 32'h3FFF_FFFF;
        for (int k = 0; k < S; k++) begin
            logic [31:0] w;
            if ($urandom_range(0, 1) == 1) w = $urandom();
            else w = 32'(int'($urandom_range(0, 2 * span)) - span);
            tdata[k*AW +: AW] = w;
            texp[k*DW +: DW]  = DW'(model(longint'($signed(w)), cur_relu, cur_shift));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{relu: 1'b0, shift: 5'd0, acc: '{300, -300, 127, -128},
                   exp: '{127, -128, 127, -128}};
        tbl[1] = '{relu: 1'b1, shift: 5'd2, acc: '{6, 5, -7, 0}, exp: '{2, 1, 0, 0}};
        tbl[2] = '{relu: 1'b0, shift: 5'd1, acc: '{-3, -1, 200, 255}, exp: '{-1, 0, 100, 127}};
        tbl[3] = '{relu: 1'b0, shift: 5'd4, acc: '{-1, -9, 2000, -2100},
                   exp: '{0, -1, 125, -128}};
        tbl[4] = '{relu: 1'b0, shift: 5'd31,
                   acc: '{32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000, 32'hC000_0000},
                   exp: '{1, -1, 1, 0}};
        tbl[5] = '{relu: 1'b1, shift: 5'd0, acc: '{50, -1, 32'h8000_0000, 32'h7FFF_FFFF},
                   exp: '{50, 0, 0, 127}};
        tbl[6] = '{relu: 1'b1, shift: 5'd3, acc: '{-100, 11, 12, 1019}, exp: '{0, 1, 2, 127}};

        rst          = 1'b1;
        start        = 1'b0;
        relu_en      = 1'b0;
        shift        = '0;
        wb.acc_valid = 1'b0;
        wb.acc_data  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs();

        // Conversion table: element k of the tile takes row entry k mod 4.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            start_layer(tbl[i].relu, tbl[i].shift);
            for (int k = 0; k < S; k++) begin
                tdata[k*AW +: AW] = tbl[i].acc[k % 4];
                texp[k*DW +: DW]  = tbl[i].exp[k % 4][DW-1:0];
            end
            send_tile(tdata, texp);
            drain_wait();
        end

        // Backpressure, then start/acc_valid asserted during a drain.
        do_reset();
        start_layer(1'b0, 5'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_no_write", longint'(wb.ofm_we), 0);
            check("bp_busy", longint'(busy), 1);
            check("bp_ready", longint'(wb.acc_ready), 1);
        end
        build_ramp();
        send_tile(tdata, texp);
        start        = 1'b1;
        wb.acc_valid = 1'b1;
        wb.acc_data  = ~tdata;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("drain_ready_low", longint'(wb.acc_ready), 0);
            check("drain_writing", longint'(wb.ofm_we), 1);
        end
        start        = 1'b0;
        wb.acc_valid = 1'b0;
        drain_wait();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stray_write", longint'(wb.ofm_we), 0);
            check("wait_ready", longint'(wb.acc_ready), 1);
            check("wait_busy", longint'(busy), 1);
        end
        build_random();
        send_tile(tdata, texp);
        drain_wait();

        // Reset at the 5th write of tile 3.
        do_reset();
        start_layer(1'b0, 5'd0);
        for (int t = 0; t < 4; t++) begin
            build_random();
            send_tile(tdata, texp);
        end
        repeat (4) @(negedge clk);
        check("fifth_write_we", longint'(wb.ofm_we), 1);
        check("fifth_write_addr", longint'(wb.ofm_addr), 3 * S + 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check_reset_outputs();
        start_layer(1'b0, 5'd0);
        build_ramp();
        send_tile(tdata, texp);
        check("restart_addr_zero", longint'(wb.ofm_addr), 0);
        drain_wait();

        // Randomized configurations and tiles.
        for (int c = 0; c < 4; c++) begin
            do_reset();
            start_layer(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            for (int t = 0; t < 30; t++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                build_random();
                send_tile(tdata, texp);
            end
            drain_wait();
        end

        // Full layer with the k-8 ramp in every tile.
        do_reset();
        done_cnt  = 0;
        write_cnt = 0;
        start_layer(1'b0, 5'd0);
        build_ramp();
        for (int t = 0; t < NTILES; t++) begin
            send_tile(tdata, texp);
        end
        begin
            int w = 0;
            while (done_cnt == 0 && w < 4 * S) begin
                @(negedge clk);
                w++;
            end
        end
        repeat (3) @(negedge clk);
        check("layer_done_pulses", longint'(done_cnt), 1);
        check("layer_write_count", longint'(write_cnt), NTILES * S);
        check("layer_queue_empty", longint'(exp_q.size()), 0);
        check("idle_busy", longint'(busy), 0);
        check("idle_ready", longint'(wb.acc_ready), 0);
        check("idle_done", longint'(done), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ofm_writeback.md
OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
REQ-001 Parameter SYSTOLIC_SIZE, default 16: results per tile (one row segment of one filter).
REQ-002 Parameter ACC_WIDTH, default 32: signed accumulator width.
REQ-003 Parameter DATA_WIDTH, default 8: signed output element width.
REQ-004 Parameter NUM_FILTERS, default 16: output channels per layer.
REQ-005 Parameter OUT_H, default 32, and OUT_W, default 32: output map size; OUT_W SHALL be a multiple of SYSTOLIC_SIZE.
REQ-006 Parameter ADDR_WIDTH, default 15: OFM word address width; 2^ADDR_WIDTH SHALL be at least NUM_FILTERS*OUT_H*OUT_W.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 start  input  1  layer start pulse.
REQ-010 relu_en  input  1  ReLU enable; sampled on an accepted start.
REQ-011 shift  input  5  requantisation right-shift; sampled on an accepted start.
REQ-012 acc_valid  input  1  tile available.
REQ-013 acc_ready  output  1  block accepts a tile.
REQ-014 acc_data  input  SYSTOLIC_SIZE*ACC_WIDTH  tile; element k at bits [k*ACC_WIDTH +: ACC_WIDTH].
REQ-015 ofm_we  output  1  OFM write strobe.
REQ-016 ofm_addr  output  ADDR_WIDTH  OFM word address.
REQ-017 ofm_wdata  output  DATA_WIDTH  OFM write data.
REQ-018 busy  output  1  high from an accepted start until done.
REQ-019 done  output  1  one-cycle pulse after the last layer write.

Function
REQ-020 FSM states: IDLE, WAIT_TILE, DRAIN, FINISH.
REQ-021 IDLE: start=1 -> WAIT_TILE; capture relu_en and shift; clear the filter, row and segment counters.
REQ-022 WAIT_TILE: acc_ready=1; acc_valid=1 -> latch acc_data, go to DRAIN; otherwise hold state.
REQ-023 acc_ready SHALL be 0 in every state except WAIT_TILE; acc_valid outside WAIT_TILE SHALL be ignored.
REQ-024 DRAIN: one write per cycle, element 0 first, exactly SYSTOLIC_SIZE cycles with ofm_we=1; the first write is in the cycle after the handshake.
REQ-025 Write address = (f*OUT_H + r)*OUT_W + s*SYSTOLIC_SIZE + k, where f = filter, r = row, s = segment and k = element index.
REQ-026 Tile order: segment fastest, then row, then filter; counters advance after the last element of a tile.
REQ-027 After the last element of a tile: if it is the final tile (f=NUM_FILTERS-1, r=OUT_H-1, s=OUT_W/SYSTOLIC_SIZE-1) -> FINISH; otherwise -> WAIT_TILE.
REQ-028 FINISH lasts one cycle: done=1, busy=0, then IDLE.
REQ-029 busy=1 in WAIT_TILE and DRAIN only.
REQ-030 Element conversion steps, in order:
- (a) If relu_en and the value is negative, the value becomes 0.
- (b) If shift>0, add 2^(shift-1), then arithmetic right shift by shift; the add uses ACC_WIDTH+1 bits, so it cannot overflow.
- (c) Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-031 Conversion SHALL be combinational from the latched element; ofm_wdata SHALL be registered together with ofm_we and ofm_addr.
REQ-032 start outside IDLE SHALL be ignored; relu_en and shift changes mid-layer SHALL have no effect.
REQ-033 When ofm_we=0, ofm_addr and ofm_wdata SHALL hold their last values.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL enter IDLE with:
- outputs: acc_ready=0, ofm_we=0, ofm_addr=0, ofm_wdata=0, busy=0, done=0;
- all counters, the tile register and the captured config cleared.
REQ-035 rst during DRAIN SHALL abort the tile; no ofm_we occurs in the cycle after reset; a new start is required to resume.
REQ-036 rst has priority over start and acc_valid in the same cycle.

Verification
REQ-037 The bench SHALL cover these directed scenarios:
- Full layer, defaults, relu_en=0, shift=0, acc_data element k = k-8 in every tile -> 1024 tiles, 16384 writes, addresses 0..16383 in order, wdata -8..7 repeating, one done pulse.
- Saturation: elements 300, -300, 127, -128, shift=0 -> wdata 127, -128, 127, -128.
- Rounding plus ReLU: relu_en=1, shift=2, elements 6, 5, -7 -> wdata 2, 1, 0.
- Backpressure: acc_valid held low for 10 cycles in WAIT_TILE -> no writes, busy=1, acc_ready=1; the tile is accepted on the first acc_valid=1.
- Restrictions: start during DRAIN is ignored; acc_valid during DRAIN is not accepted (acc_ready=0).
- Reset: rst asserted at the 5th write of tile 3 -> the next cycle has ofm_we=0, busy=0 and all outputs at reset values; after a new start, the first write goes to address 0.
